// File: rtl/multi_channel_debouncer.sv
`default_nettype none
// ============================================================================
// multi_channel_debouncer : N-channel switch debouncer, per-channel EARLY/LATE
// Rev 1.0
// ============================================================================
module multi_channel_debouncer #(
  parameter int N_CH          = 4,
  parameter int CLK_PERIOD_NS = 10,
  parameter int DELAY_NS      = 100,
  parameter int SYNC_STAGES   = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] btn_i,
  input  logic [N_CH-1:0] mode_i,
  output logic [N_CH-1:0] debounced_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o
);

  localparam int C_D  = DELAY_NS / CLK_PERIOD_NS;
  localparam int C_CW = (C_D < 1) ? 1 : $clog2(C_D + 1);
  localparam logic [C_CW-1:0] C_LOAD = (C_D < 1) ? '0 : C_CW'(C_D - 1);

  if (C_D < 1) begin : g_err_delay
    $error("multi_channel_debouncer: DELAY_NS/CLK_PERIOD_NS must be >= 1");
  end

  if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_err_sync
    $error("multi_channel_debouncer: SYNC_STAGES must be 0..3");
  end

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_W_RISE = 2'd1,
    ST_HIGH   = 2'd2,
    ST_W_FALL = 2'd3
  } state_t;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic w_s;

    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = btn_i[c];
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge clk_i) begin
        if (rst_i) r_sync <= '0;
        else       r_sync <= (r_sync << 1) | SYNC_STAGES'(btn_i[c]);
      end
      assign w_s = r_sync[SYNC_STAGES-1];
    end

    state_t          r_state, w_state_nxt;
    logic [C_CW-1:0] r_cnt, w_cnt_nxt;
    logic            r_mode, w_mode_nxt;
    logic            r_deb, w_deb_nxt;
    logic            r_rise, r_fall;
    logic            w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state <= ST_LOW;
        r_cnt   <= '0;
        r_mode  <= 1'b0;
        r_deb   <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_mode  <= w_mode_nxt;
        r_deb   <= w_deb_nxt;
        r_rise  <= w_deb_nxt & ~r_deb;
        r_fall  <= ~w_deb_nxt & r_deb;
      end
    end

    // Mode is only taken from mode_i in the stable states; a wait keeps the
    // mode it was entered with.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_mode_nxt  = r_mode;
      case (r_state)
        ST_LOW: begin
          w_mode_nxt = mode_i[c];
          if (w_s) begin
            w_state_nxt = ST_W_RISE;
            w_cnt_nxt   = C_LOAD;
          end
        end
        ST_W_RISE: begin
          if (!r_mode && !w_s)  w_state_nxt = ST_LOW;
          else if (w_cnt_zero)  w_state_nxt = ST_HIGH;
          else                  w_cnt_nxt   = r_cnt - C_CW'(1);
        end
        ST_HIGH: begin
          w_mode_nxt = mode_i[c];
          if (!w_s) begin
            w_state_nxt = ST_W_FALL;
            w_cnt_nxt   = C_LOAD;
          end
        end
        ST_W_FALL: begin
          if (!r_mode && w_s)   w_state_nxt = ST_HIGH;
          else if (w_cnt_zero)  w_state_nxt = ST_LOW;
          else                  w_cnt_nxt   = r_cnt - C_CW'(1);
        end
        default: w_state_nxt = ST_LOW;
      endcase
      // EARLY shows the new level during its lockout; LATE holds the old one.
      w_deb_nxt = (w_state_nxt == ST_HIGH)
               || ((w_state_nxt == ST_W_RISE) &&  w_mode_nxt)
               || ((w_state_nxt == ST_W_FALL) && !w_mode_nxt);
    end

    assign debounced_o[c] = r_deb;
    assign rise_o[c]      = r_rise;
    assign fall_o[c]      = r_fall;
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_debouncer.sv
`default_nettype none
// ============================================================================
// tb_multi_channel_debouncer : scoreboard bench for multi_channel_debouncer
// Rev 1.0
// ============================================================================
module tb_multi_channel_debouncer;

  localparam int N_CH = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N_CH-1:0] btn_i;
  logic [N_CH-1:0] mode_i;
  logic [N_CH-1:0] debounced_o;
  logic [N_CH-1:0] rise_o;
  logic [N_CH-1:0] fall_o;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  // Expected pulses per channel, encoded as cycle*2 + (1 for rise, 0 for fall).
  int exp_q[N_CH][$];

  multi_channel_debouncer #(
    .N_CH          (N_CH),
    .CLK_PERIOD_NS (10),
    .DELAY_NS      (100),
    .SYNC_STAGES   (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .btn_i       (btn_i),
    .mode_i      (mode_i),
    .debounced_o (debounced_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic seg(input logic [N_CH-1:0] mask, input logic lvl, input int n);
    for (int i = 0; i < N_CH; i++) if (mask[i]) btn_i[i] = lvl;
    tick(n);
  endtask

  task automatic expect_ev(input int ch, input logic rise, input int at);
    exp_q[ch].push_back(at * 2 + int'(rise));
  endtask

  // Monitor: every pulse must match the head of its channel's queue.
  always @(negedge clk_i) begin
    for (int ch = 0; ch < N_CH; ch++) begin
      if (rise_o[ch] || fall_o[ch]) begin
        check($sformatf("ch%0d rise_fall_exclusive", ch), int'(rise_o[ch] & fall_o[ch]), 0);
        if (exp_q[ch].size() == 0)
          check($sformatf("ch%0d unexpected_pulse(cyc*2+rise)", ch),
                cyc * 2 + int'(rise_o[ch]), -1);
        else
          check($sformatf("ch%0d pulse(cyc*2+rise)", ch),
                cyc * 2 + int'(rise_o[ch]), exp_q[ch].pop_front());
        check($sformatf("ch%0d level_at_pulse", ch), int'(debounced_o[ch]), int'(rise_o[ch]));
      end
    end
  end

  initial begin
    int c;
    rst_i  = 1'b1;
    btn_i  = '1;
    mode_i = 4'b0001;

    // 1: reset with all inputs high, then release
    tick(3);
    check("rst_level", int'(debounced_o), 0);
    check("rst_pulses", int'(rise_o | fall_o), 0);
    c = cyc;
    rst_i = 1'b0;
    expect_ev(0, 1'b1, c + 3);
    for (int ch = 1; ch < N_CH; ch++) expect_ev(ch, 1'b1, c + 13);
    tick(2);
    check("s1_before_rise", int'(debounced_o), 0);
    tick(1);
    check("s1_early_rise", int'(debounced_o), 1);
    tick(17);
    check("s1_all_high", int'(debounced_o), 15);
    c = cyc;
    btn_i = '0;
    expect_ev(0, 1'b0, c + 3);
    for (int ch = 1; ch < N_CH; ch++) expect_ev(ch, 1'b0, c + 13);
    tick(20);
    check("s1_all_low", int'(debounced_o), 0);

    // 2: EARLY ch0, bounce inside the lockout
    c = cyc;
    expect_ev(0, 1'b1, c + 3);
    seg(4'b0001, 1'b1, 2); seg(4'b0001, 1'b0, 2);
    seg(4'b0001, 1'b1, 2); seg(4'b0001, 1'b0, 2);
    check("s2_high_in_bounce", int'(debounced_o[0]), 1);
    seg(4'b0001, 1'b1, 40);
    check("s2_high_stable", int'(debounced_o[0]), 1);
    c = cyc;
    expect_ev(0, 1'b0, c + 3);
    seg(4'b0001, 1'b0, 5);
    check("s2_low_in_bounce", int'(debounced_o[0]), 0);
    seg(4'b0001, 1'b1, 5); seg(4'b0001, 1'b0, 30);
    check("s2_low_stable", int'(debounced_o[0]), 0);

    // 3: LATE ch1, 5-cycle bounces
    c = cyc;
    expect_ev(1, 1'b1, c + 33);
    seg(4'b0010, 1'b1, 5); seg(4'b0010, 1'b0, 5);
    seg(4'b0010, 1'b1, 5); seg(4'b0010, 1'b0, 5);
    check("s3_low_in_bounce", int'(debounced_o[1]), 0);
    seg(4'b0010, 1'b1, 12);
    check("s3_before_rise", int'(debounced_o[1]), 0);
    tick(1);
    check("s3_rise", int'(debounced_o[1]), 1);
    tick(10);
    seg(4'b0010, 1'b0, 5);
    check("s3_glitch_held", int'(debounced_o[1]), 1);
    seg(4'b0010, 1'b1, 20);
    check("s3_after_glitch", int'(debounced_o[1]), 1);
    c = cyc;
    expect_ev(1, 1'b0, c + 23);
    seg(4'b0010, 1'b0, 5); seg(4'b0010, 1'b1, 5); seg(4'b0010, 1'b0, 12);
    check("s3_before_fall", int'(debounced_o[1]), 1);
    tick(1);
    check("s3_fall", int'(debounced_o[1]), 0);
    tick(10);

    // 4: ch0 EARLY and ch1 LATE bouncing together, ch2/ch3 idle
    c = cyc;
    expect_ev(0, 1'b1, c + 3);
    expect_ev(1, 1'b1, c + 21);
    seg(4'b0011, 1'b1, 2); seg(4'b0011, 1'b0, 2);
    seg(4'b0011, 1'b1, 2); seg(4'b0011, 1'b0, 2);
    check("s4_mid_press", int'(debounced_o), 1);
    seg(4'b0011, 1'b1, 30);
    check("s4_both_high", int'(debounced_o), 3);
    c = cyc;
    expect_ev(0, 1'b0, c + 3);
    expect_ev(1, 1'b0, c + 23);
    seg(4'b0011, 1'b0, 5);
    check("s4_mid_release", int'(debounced_o), 2);
    seg(4'b0011, 1'b1, 5); seg(4'b0011, 1'b0, 30);
    check("s4_all_low", int'(debounced_o), 0);

    // 5: mode flip during a LATE wait on ch1
    c = cyc;
    expect_ev(1, 1'b1, c + 13);
    btn_i[1] = 1'b1;
    tick(5);
    mode_i[1] = 1'b1;
    check("s5_wait_late", int'(debounced_o[1]), 0);
    tick(7);
    check("s5_before_rise", int'(debounced_o[1]), 0);
    tick(1);
    check("s5_rise", int'(debounced_o[1]), 1);
    tick(10);
    c = cyc;
    expect_ev(1, 1'b0, c + 3);
    btn_i[1] = 1'b0;
    tick(3);
    check("s5_early_fall", int'(debounced_o[1]), 0);
    tick(20);
    mode_i[1] = 1'b0;

    // 6: reset during EARLY lockout on ch0
    c = cyc;
    expect_ev(0, 1'b1, c + 3);
    btn_i[0] = 1'b1;
    tick(5);
    check("s6_in_lockout", int'(debounced_o[0]), 1);
    rst_i = 1'b1;
    tick(1);
    check("s6_reset_level", int'(debounced_o), 0);
    check("s6_reset_no_fall", int'(fall_o), 0);
    rst_i = 1'b0;
    expect_ev(0, 1'b1, c + 9);
    tick(2);
    check("s6_before_rerise", int'(debounced_o[0]), 0);
    tick(1);
    check("s6_rerise", int'(debounced_o[0]), 1);
    tick(20);
    c = cyc;
    expect_ev(0, 1'b0, c + 3);
    btn_i[0] = 1'b0;
    tick(20);
    check("s6_final_low", int'(debounced_o), 0);

    for (int ch = 0; ch < N_CH; ch++)
      check($sformatf("ch%0d missing_pulses", ch), exp_q[ch].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
